// File: rtl/video_text_writer_pkg.sv
// Shared display-memory types for the text-mode test blocks: address/data/colour
// fields, pass modes and the colour-collision helper.
package video_text_writer_pkg;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int COLOR_W = 4;

  typedef logic [ADDR_W-1:0]  disp_addr_t;
  typedef logic [DATA_W-1:0]  disp_data_t;
  typedef logic [COLOR_W-1:0] color_t;

  typedef enum logic [1:0] {
    MODE_MSG   = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_CLEAR = 2'd2
  } wr_mode_t;

  localparam logic [7:0] CHAR_SPACE = 8'h20;

  // Keep the glyph visible when foreground and background collide.
  function automatic color_t fix_fore(input color_t fore, input color_t back);
    return (fore == back) ? color_t'(fore + 4'd5) : fore;
  endfunction

endpackage

// File: rtl/video_text_writer_frame_timer.sv
// End-of-frame divider: one-cycle tick on every DELAY_FRAMES-th eof_i pulse.
module video_frame_timer #(
  parameter int DELAY_FRAMES = 300
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic eof_i,
  output logic tick_o
);

  localparam int CW = (DELAY_FRAMES > 1) ? $clog2(DELAY_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DELAY_FRAMES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (eof_i) begin
        if (r_cnt == CNT_LAST) begin
          r_cnt  <= '0;
          r_tick <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign tick_o = r_tick;

endmodule

// File: rtl/video_text_writer.sv
// Text-mode test-pattern writer: prints a message, a char/colour ramp or a clear
// screen into display RAM through a valid/ready write port, once per trigger.
module video_text_writer
  import video_text_writer_pkg::*;
#(
  parameter int                     COLS         = 80,
  parameter int                     ROWS         = 30,
  parameter int                     DELAY_FRAMES = 300,
  parameter int                     MSG_LEN      = 20,
  parameter logic [MSG_LEN*8-1:0]   MSG          = "Hello Upduino VGA!  "
) (
  input  logic               clk,
  input  logic               rst_ni,
  input  logic               eof_i,
  input  logic               start_i,
  input  logic [1:0]         mode_i,
  input  logic               wr_ready_i,
  output logic               wr_en_o,
  output logic [ADDR_W-1:0]  wr_addr_o,
  output logic [DATA_W-1:0]  wr_data_o,
  output logic               busy_o
);

  localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);
  localparam disp_addr_t SCR_LAST = disp_addr_t'(COLS * ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_PRINT, S_FILL, S_NEXT} state_t;

  state_t           r_state, w_state_nxt;
  wr_mode_t         r_mode;
  disp_addr_t       r_cursor;
  disp_addr_t       r_faddr;
  logic [IDX_W-1:0] r_idx;
  color_t           r_fcolor;
  color_t           r_bcolor;

  logic       w_tick;
  logic       w_trig;
  logic       w_acc;
  logic [7:0] w_msg_char;
  color_t     w_fore;

  video_frame_timer #(
    .DELAY_FRAMES(DELAY_FRAMES)
  ) u_frame_timer (
    .clk   (clk),
    .rst_ni(rst_ni),
    .eof_i (eof_i),
    .tick_o(w_tick)
  );

  assign w_trig = w_tick | start_i;
  assign w_acc  = wr_en_o & wr_ready_i;
  assign busy_o = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_trig) w_state_nxt = (mode_i == 2'd1 || mode_i == 2'd2) ? S_FILL : S_PRINT;
      S_PRINT: if (w_acc && r_idx == IDX_LAST) w_state_nxt = S_NEXT;
      S_FILL:  if (w_acc && r_faddr == SCR_LAST) w_state_nxt = S_NEXT;
      S_NEXT:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mode   <= MODE_MSG;
      r_cursor <= '0;
      r_faddr  <= '0;
      r_idx    <= '0;
      r_fcolor <= 4'd1;
      r_bcolor <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            r_idx   <= '0;
            r_faddr <= '0;
            case (mode_i)
              2'd1:    r_mode <= MODE_RAMP;
              2'd2:    r_mode <= MODE_CLEAR;
              default: r_mode <= MODE_MSG;
            endcase
          end
        end
        S_PRINT: begin
          if (w_acc) begin
            r_cursor <= (r_cursor == SCR_LAST) ? '0 : r_cursor + 1'b1;
            r_fcolor <= r_fcolor + 1'b1;
            r_idx    <= r_idx + 1'b1;
          end
        end
        S_FILL: begin
          if (w_acc) begin
            r_faddr <= r_faddr + 1'b1;
            if (r_faddr == SCR_LAST && r_mode == MODE_CLEAR) r_cursor <= '0;
          end
        end
        S_NEXT: begin
          r_bcolor <= r_bcolor + 1'b1;
          r_fcolor <= r_bcolor + 4'd3;
        end
        default: ;
      endcase
    end
  end

  // Outputs come straight from registered state, so they hold during a stall.
  always_comb begin
    w_msg_char = 8'h00;
    for (int k = 0; k < MSG_LEN; k++) begin
      if (r_idx == IDX_W'(k)) w_msg_char = MSG[(MSG_LEN-1-k)*8 +: 8];
    end
  end

  always_comb begin
    wr_en_o   = 1'b0;
    wr_addr_o = '0;
    wr_data_o = '0;
    w_fore    = r_fcolor;
    case (r_state)
      S_PRINT: begin
        wr_en_o   = 1'b1;
        wr_addr_o = r_cursor;
        wr_data_o = {r_bcolor, fix_fore(r_fcolor, r_bcolor), w_msg_char};
      end
      S_FILL: begin
        wr_en_o   = 1'b1;
        wr_addr_o = r_faddr;
        if (r_mode == MODE_RAMP) begin
          w_fore    = r_faddr[11:8];
          wr_data_o = {r_bcolor, fix_fore(w_fore, r_bcolor), r_faddr[7:0]};
        end else begin
          wr_data_o = {r_bcolor, fix_fore(r_fcolor, r_bcolor), CHAR_SPACE};
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_video_text_writer.sv
// Directed/randomised bench for video_text_writer against a pass-level reference model.
module tb_video_text_writer;

  localparam int COLS = 16;
  localparam int ROWS = 17;
  localparam int SCR  = COLS * ROWS;
  localparam int MLEN = 20;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        eof_i;
  logic        start_i;
  logic [1:0]  mode_i;
  logic        wr_ready_i;
  logic        wr_en_o;
  logic [15:0] wr_addr_o;
  logic [15:0] wr_data_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  string msg = "Hello Upduino VGA!  ";
  int m_cur, m_fc, m_bc;
  int eq_addr[$];
  int eq_data[$];

  always #5 clk = ~clk;

  video_text_writer #(
    .COLS(COLS), .ROWS(ROWS), .DELAY_FRAMES(2), .MSG_LEN(MLEN)
  ) dut (
    .clk(clk), .rst_ni(rst_ni), .eof_i(eof_i), .start_i(start_i), .mode_i(mode_i),
    .wr_ready_i(wr_ready_i), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int word(input int back, input int fore, input int ch);
    if (fore == back) fore = (fore + 5) % 16;
    return (back << 12) | (fore << 8) | ch;
  endfunction

  task automatic model_reset();
    m_cur = 0; m_fc = 1; m_bc = 0;
    eq_addr.delete(); eq_data.delete();
  endtask

  // Expected word list for one whole pass, then the end-of-pass colour update.
  task automatic model_pass(input int mode);
    eq_addr.delete(); eq_data.delete();
    if (mode == 1 || mode == 2) begin
      for (int a = 0; a < SCR; a++) begin
        eq_addr.push_back(a);
        if (mode == 1) eq_data.push_back(word(m_bc, (a >> 8) % 16, a % 256));
        else           eq_data.push_back(word(m_bc, m_fc, 32));
      end
      if (mode == 2) m_cur = 0;
    end else begin
      for (int i = 0; i < MLEN; i++) begin
        eq_addr.push_back(m_cur);
        eq_data.push_back(word(m_bc, m_fc, int'(msg[i])));
        m_cur = (m_cur + 1) % SCR;
        m_fc  = (m_fc + 1) % 16;
      end
    end
    m_fc = (m_bc + 3) % 16;
    m_bc = (m_bc + 1) % 16;
  endtask

  task automatic run_pass(input int mode, input bit use_eof, input bit rnd,
                          input bit poke, input int exp_busy);
    int cycles, n, w, exp_n, budget;
    bit stalled;
    logic [15:0] s_addr, s_data;
    model_pass(mode);
    exp_n  = eq_addr.size();
    budget = 4 * SCR + 100;
    mode_i = 2'(mode);
    if (use_eof) begin
      repeat (2) begin
        eof_i = 1'b1; @(negedge clk);
        eof_i = 1'b0; @(negedge clk);
      end
    end else begin
      start_i = 1'b1; @(negedge clk);
      start_i = 1'b0;
      chk("start_latency_busy", 32'(busy_o), 32'd1);
      chk("start_latency_wr_en", 32'(wr_en_o), 32'd1);
    end
    w = 0;
    while (busy_o !== 1'b1 && w < 6) begin @(negedge clk); w++; end
    chk("pass_started", 32'(busy_o), 32'd1);
    cycles = 0; n = 0; stalled = 1'b0; s_addr = '0; s_data = '0;
    while (busy_o === 1'b1 && cycles < budget) begin
      cycles++;
      start_i    = (poke && cycles == 3);
      mode_i     = 2'($urandom_range(0, 3));
      wr_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) begin
        chk("stall_wr_en", 32'(wr_en_o), 32'd1);
        chk("stall_addr", 32'(wr_addr_o), 32'(s_addr));
        chk("stall_data", 32'(wr_data_o), 32'(s_data));
      end
      stalled = 1'b0;
      if (wr_en_o === 1'b1) begin
        if (wr_ready_i) begin
          n++;
          if (eq_addr.size() > 0) begin
            chk("word_addr", 32'(wr_addr_o), 32'(eq_addr[0]));
            chk("word_data", 32'(wr_data_o), 32'(eq_data[0]));
            void'(eq_addr.pop_front());
            void'(eq_data.pop_front());
          end
        end else begin
          stalled = 1'b1;
          s_addr  = wr_addr_o;
          s_data  = wr_data_o;
        end
      end
      @(negedge clk);
    end
    start_i = 1'b0; wr_ready_i = 1'b1;
    chk("pass_in_bound", 32'(cycles < budget), 32'd1);
    chk("word_count", 32'(n), 32'(exp_n));
    if (exp_busy > 0) chk("busy_cycles", 32'(cycles), 32'(exp_busy));
  endtask

  task automatic reset_mid_fill();
    int n, guard, quiet;
    model_pass(1);
    mode_i = 2'd1; start_i = 1'b1; @(negedge clk);
    start_i = 1'b0;
    n = 0; guard = 0;
    while (n < 5 && guard < 50) begin
      if (wr_en_o === 1'b1 && wr_ready_i) begin
        chk("pre_reset_addr", 32'(wr_addr_o), 32'(eq_addr[0]));
        chk("pre_reset_data", 32'(wr_data_o), 32'(eq_data[0]));
        void'(eq_addr.pop_front());
        void'(eq_data.pop_front());
        n++;
      end
      guard++;
      @(negedge clk);
    end
    chk("pre_reset_words", 32'(n), 32'd5);
    rst_ni = 1'b0;
    #1;
    chk("async_rst_wr_en", 32'(wr_en_o), 32'd0);
    chk("async_rst_addr", 32'(wr_addr_o), 32'd0);
    chk("async_rst_data", 32'(wr_data_o), 32'd0);
    chk("async_rst_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    model_reset();
    quiet = 0;
    repeat (10) begin
      @(negedge clk);
      if (wr_en_o !== 1'b0 || busy_o !== 1'b0) quiet++;
    end
    chk("quiet_after_reset", 32'(quiet), 32'd0);
  endtask

  initial begin
    int quiet;
    rst_ni = 1'b0; eof_i = 1'b0; start_i = 1'b0; mode_i = 2'd0; wr_ready_i = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_wr_en", 32'(wr_en_o), 32'd0);
    chk("reset_addr", 32'(wr_addr_o), 32'd0);
    chk("reset_data", 32'(wr_data_o), 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);
    rst_ni = 1'b1;
    @(negedge clk);

    run_pass(0, 1'b1, 1'b0, 1'b0, MLEN + 1);
    for (int p = 0; p < 14; p++) run_pass($urandom_range(0, 1) ? 0 : 3, 1'b0, 1'b1, 1'b0, 0);
    run_pass(1, 1'b0, 1'b0, 1'b0, SCR + 1);
    run_pass(2, 1'b0, 1'b1, 1'b1, 0);
    quiet = 0;
    repeat (5) begin
      @(negedge clk);
      if (wr_en_o !== 1'b0 || busy_o !== 1'b0) quiet++;
    end
    chk("no_queued_pass", 32'(quiet), 32'd0);
    run_pass(0, 1'b0, 1'b0, 1'b0, MLEN + 1);
    reset_mid_fill();
    run_pass(3, 1'b0, 1'b0, 1'b0, MLEN + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
